// File: rtl/address_sequencer.sv
// Bounded address sequencer: base..limit (inclusive), programmable stride,
// relative branching, wrap or one-shot mode, valid/ready output handshake.
// Optional return stack for call/return redirects: define ADDR_CALL_STACK_EN.
module address_sequencer #(
   parameter int unsigned NO_BITS     = 32,
   parameter int unsigned STRIDE_BITS = 4,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NO_BITS-1:0]     base_addr,
   input  logic [NO_BITS-1:0]     limit_addr,
   input  logic [STRIDE_BITS-1:0] stride,
   input  logic                   wrap_mode,
   input  logic                   branch_en,
   input  logic [NO_BITS-1:0]     branch_off,
   input  logic                   addr_ready,
`ifdef ADDR_CALL_STACK_EN
   input  logic                   call_en,
   input  logic                   ret_en,
   output logic                   stack_err,
`endif
   output logic                   addr_valid,
   output logic [NO_BITS-1:0]     address,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Stack depth of zero is meaningless; reject it at elaboration.
   if (STACK_DEPTH < 1) begin : g_depth_chk
      $error("address_sequencer: STACK_DEPTH must be >= 1");
   end

   state_t                 state_q, state_d;
   logic [NO_BITS-1:0]     address_q, address_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [NO_BITS-1:0]     base_q, base_d;
   logic [NO_BITS-1:0]     limit_q, limit_d;
   logic [STRIDE_BITS-1:0] stride_q, stride_d;
   logic                   wrap_q, wrap_d;

   logic                   fire;
   logic [NO_BITS:0]       nxt_w;
   logic [NO_BITS:0]       addr_w;
   logic [NO_BITS:0]       stride_w;
   logic [NO_BITS:0]       off_w;

`ifdef ADDR_CALL_STACK_EN
   localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [NO_BITS-1:0] stack_q [STACK_DEPTH];
   logic [NO_BITS-1:0] stack_d [STACK_DEPTH];
   logic [SP_W-1:0]    sp_q, sp_d;
   logic               err_q, err_d;

   assign stack_err = err_q;
`endif

   assign fire       = valid_q & addr_ready;
   assign addr_valid = valid_q;
   assign address    = address_q;
   assign busy       = busy_q;
   assign done       = done_q;

   // Operands extended by one bit so a carry / negative result is visible.
   assign addr_w   = {1'b0, address_q};
   assign stride_w = {1'b0, NO_BITS'(stride_q)};
   assign off_w    = {branch_off[NO_BITS-1], branch_off};

   // Next-state, next-address, config latch and stack update.
   always_comb begin
      state_d   = state_q;
      address_d = address_q;
      valid_d   = valid_q;
      base_d    = base_q;
      limit_d   = limit_q;
      stride_d  = stride_q;
      wrap_d    = wrap_q;
      nxt_w     = addr_w + stride_w;
`ifdef ADDR_CALL_STACK_EN
      stack_d   = stack_q;
      sp_d      = sp_q;
      err_d     = err_q;
`endif

      if (start) begin
         base_d   = base_addr;
         limit_d  = limit_addr;
         stride_d = stride;
         wrap_d   = wrap_mode;
`ifdef ADDR_CALL_STACK_EN
         sp_d     = '0;
         err_d    = 1'b0;
`endif
         if (base_addr > limit_addr) begin
            state_d = DONE;
            valid_d = 1'b0;
         end else begin
            state_d   = RUN;
            valid_d   = 1'b1;
            address_d = base_addr;
         end
      end else if (state_q == RUN && fire) begin
`ifdef ADDR_CALL_STACK_EN
         if (call_en) begin
            nxt_w = addr_w + off_w;
            if (sp_q == SP_W'(STACK_DEPTH)) begin
               err_d = 1'b1;
            end else begin
               stack_d[IDX_W'(sp_q)] = address_q + NO_BITS'(stride_q);
               sp_d = sp_q + 1'b1;
            end
         end else if (ret_en) begin
            if (sp_q == '0) begin
               err_d = 1'b1;
            end else begin
               nxt_w = {1'b0, stack_q[IDX_W'(sp_q - 1'b1)]};
               sp_d  = sp_q - 1'b1;
            end
         end else if (branch_en) begin
            nxt_w = addr_w + off_w;
         end
`else
         if (branch_en) begin
            nxt_w = addr_w + off_w;
         end
`endif
         if (nxt_w[NO_BITS] || (nxt_w[NO_BITS-1:0] > limit_q)) begin
            if (wrap_q) begin
               address_d = base_q;
            end else begin
               state_d = DONE;
               valid_d = 1'b0;
            end
         end else begin
            address_d = nxt_w[NO_BITS-1:0];
         end
      end

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         address_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         base_q    <= '0;
         limit_q   <= '0;
         stride_q  <= '0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         base_q    <= base_d;
         limit_q   <= limit_d;
         stride_q  <= stride_d;
         wrap_q    <= wrap_d;
      end
   end

`ifdef ADDR_CALL_STACK_EN
   // Return-stack storage, pointer and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            stack_q[i] <= '0;
         end
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         stack_q <= stack_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer with immediate-assertion checks.
module tb_address_sequencer;

   localparam int unsigned NB    = 32;
   localparam int unsigned SB    = 4;
   localparam int unsigned DEPTH = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic [NB-1:0] base_addr;
   logic [NB-1:0] limit_addr;
   logic [SB-1:0] stride;
   logic          wrap_mode;
   logic          branch_en;
   logic [NB-1:0] branch_off;
   logic          addr_ready;
   logic          addr_valid;
   logic [NB-1:0] address;
   logic          busy;
   logic          done;
`ifdef ADDR_CALL_STACK_EN
   logic          call_en;
   logic          ret_en;
   logic          stack_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   address_sequencer #(.NO_BITS(NB), .STRIDE_BITS(SB), .STACK_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .limit_addr (limit_addr),
      .stride     (stride),
      .wrap_mode  (wrap_mode),
      .branch_en  (branch_en),
      .branch_off (branch_off),
      .addr_ready (addr_ready),
`ifdef ADDR_CALL_STACK_EN
      .call_en    (call_en),
      .ret_en     (ret_en),
      .stack_err  (stack_err),
`endif
      .addr_valid (addr_valid),
      .address    (address),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [NB-1:0] a, input logic v,
                          input logic b, input logic d);
      chk({tag, ".address"}, 64'(address), 64'(a));
      chk({tag, ".valid"},   64'(addr_valid), 64'(v));
      chk({tag, ".busy"},    64'(busy), 64'(b));
      chk({tag, ".done"},    64'(done), 64'(d));
   endtask

   task automatic cfg(input logic [NB-1:0] b, input logic [NB-1:0] l,
                      input logic [SB-1:0] s, input logic w);
      base_addr  = b;
      limit_addr = l;
      stride     = s;
      wrap_mode  = w;
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      branch_en  = 1'b0;
      branch_off = '0;
      addr_ready = 1'b1;
      cfg(32'h0, 32'h0, 4'd0, 1'b0);
`ifdef ADDR_CALL_STACK_EN
      call_en    = 1'b0;
      ret_en     = 1'b0;
`endif
      #12;
      chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step();

      // One-shot run 0x100..0x10C
      cfg(32'h100, 32'h10C, 4'd4, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("t1_a0", 32'h100, 1'b1, 1'b1, 1'b0);
      step(); chk("t1_a1", 64'(address), 64'h104);
      step(); chk("t1_a2", 64'(address), 64'h108);
      step(); chk_out("t1_a3", 32'h10C, 1'b1, 1'b1, 1'b0);
      step(); chk_out("t1_done", 32'h10C, 1'b0, 1'b0, 1'b1);
      step(); chk_out("t1_hold", 32'h10C, 1'b0, 1'b0, 1'b1);

      // Same range in wrap mode, restarted from DONE
      cfg(32'h100, 32'h10C, 4'd4, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t2_a0", 64'(address), 64'h100);
      step(); step(); step();
      chk("t2_a3", 64'(address), 64'h10C);
      step(); chk_out("t2_wrap", 32'h100, 1'b1, 1'b1, 1'b0);
      step(); chk_out("t2_a5", 32'h104, 1'b1, 1'b1, 1'b0);

      // Backpressure at 0x104; mid-run config changes must be ignored
      addr_ready = 1'b0;
      cfg(32'h0, 32'hFFF, 4'd1, 1'b0);
      step(); chk_out("t3_stall1", 32'h104, 1'b1, 1'b1, 1'b0);
      step(); chk_out("t3_stall2", 32'h104, 1'b1, 1'b1, 1'b0);
      step(); chk_out("t3_stall3", 32'h104, 1'b1, 1'b1, 1'b0);
      addr_ready = 1'b1;
      step(); chk("t3_resume", 64'(address), 64'h108);
      step(); chk("t3_stride_kept", 64'(address), 64'h10C);
      step(); chk("t3_wrap_kept", 64'(address), 64'h100);

      // Restart while RUN, then backward branch
      addr_ready = 1'b0;
      cfg(32'h200, 32'h2FF, 4'd4, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("t4_restart", 32'h200, 1'b1, 1'b1, 1'b0);
      addr_ready = 1'b1;
      step(); step(); step(); step();
      chk("t4_at210", 64'(address), 64'h210);
      branch_en  = 1'b1;
      branch_off = 32'hFFFF_FFF8;
      step();
      branch_en  = 1'b0;
      chk("t4_branch", 64'(address), 64'h208);
      step(); chk("t4_after_br", 64'(address), 64'h20C);

      // Carry-out past the top of the address space ends the run
      cfg(32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'd8, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_out("t4_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
      step(); chk_out("t4_carry", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);

      // Zero stride repeats the same address
      cfg(32'h300, 32'h3FF, 4'd0, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); chk_out("t4_stride0", 32'h300, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset mid-run
      rst = 1'b0;
      #1;
      chk_out("t5_async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      chk_out("t5_idle", 32'h0, 1'b0, 1'b0, 1'b0);

      // base > limit goes straight to DONE
      cfg(32'h20, 32'h10, 4'd4, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_bad.done",  64'(done), 64'h1);
      chk("t5_bad.valid", 64'(addr_valid), 64'h0);
      chk("t5_bad.busy",  64'(busy), 64'h0);
      step();
      chk("t5_bad_hold", 64'(done), 64'h1);

`ifdef ADDR_CALL_STACK_EN
      // Call and return
      cfg(32'h100, 32'h1FF, 4'd4, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t6_a0", 64'(address), 64'h100);
      call_en    = 1'b1;
      branch_off = 32'h40;
      step();
      call_en = 1'b0;
      chk("t6_call", 64'(address), 64'h140);
      ret_en = 1'b1;
      step();
      ret_en = 1'b0;
      chk("t6_ret", 64'(address), 64'h104);
      chk("t6_err0", 64'(stack_err), 64'h0);
      ret_en = 1'b1;
      step();
      ret_en = 1'b0;
      chk("t6_underflow_addr", 64'(address), 64'h108);
      chk("t6_underflow_err", 64'(stack_err), 64'h1);

      // start clears the sticky flag; overflow after DEPTH+1 calls
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t6_err_clr", 64'(stack_err), 64'h0);
      call_en    = 1'b1;
      branch_off = 32'h4;
      for (int i = 0; i < int'(DEPTH); i++) step();
      chk("t6_full_noerr", 64'(stack_err), 64'h0);
      step();
      call_en = 1'b0;
      chk("t6_overflow_err", 64'(stack_err), 64'h1);
      chk("t6_overflow_jump", 64'(address), 64'h114);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
